// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divide/remainder unit.
package div_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Op select = {in_signed, in_word, in_rem}
  localparam logic [2:0] OP_DIVU  = 3'b000;
  localparam logic [2:0] OP_REMU  = 3'b001;
  localparam logic [2:0] OP_DIVUW = 3'b010;
  localparam logic [2:0] OP_REMUW = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_REM   = 3'b101;
  localparam logic [2:0] OP_DIVW  = 3'b110;
  localparam logic [2:0] OP_REMW  = 3'b111;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_bit,
  input  logic [W-1:0] divisor,
  output logic         q_bit,
  output logic [W-1:0] rem_next
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem_in < divisor, so the difference always fits in W+1 bits with bit W as sign
  assign shifted  = {rem_in, dvd_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[W];
  assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle restoring divider/remainder for the RISC-V M-extension div/rem ops.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iterations.
module div_seq_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_signed,
  input  logic            in_word,
  input  logic            in_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] quo_reg, rem_reg, dvs_reg, a_ext_reg, out_result_reg;
  logic            neg_q_reg, neg_r_reg, rem_sel_reg, word_reg, dz_reg, ovf_reg;
  logic            out_valid_reg;

  logic            dec_signed, dec_word, dec_rem;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dvd_init, most_neg;
  logic            sign_a, sign_b, dz_in, ovf_in, accept;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, q_raw, q_fix, r_fix, calc_res;

  function automatic logic [XLEN-1:0] finalize(input logic dz, ovf, rem, word,
                                               input logic [XLEN-1:0] a_val, q, r);
    logic [XLEN-1:0] res;
    if (dz)       res = rem ? a_val : '1;
    else if (ovf) res = rem ? '0 : a_val;
    else          res = rem ? r : q;
    if (word) res = {{HALF{res[HALF-1]}}, res[HALF-1:0]};
    return res;
  endfunction

  always_comb begin
    dec_signed = 1'b0;
    dec_word   = 1'b0;
    dec_rem    = 1'b0;
    unique case ({in_signed, in_word, in_rem})
      OP_DIVU:  ;
      OP_REMU:  dec_rem = 1'b1;
      OP_DIVUW: dec_word = 1'b1;
      OP_REMUW: begin dec_word = 1'b1; dec_rem = 1'b1; end
      OP_DIV:   dec_signed = 1'b1;
      OP_REM:   begin dec_signed = 1'b1; dec_rem = 1'b1; end
      OP_DIVW:  begin dec_signed = 1'b1; dec_word = 1'b1; end
      OP_REMW:  begin dec_signed = 1'b1; dec_word = 1'b1; dec_rem = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    a_ext = in_a;
    b_ext = in_b;
    if (dec_word) begin
      a_ext = {{HALF{dec_signed & in_a[HALF-1]}}, in_a[HALF-1:0]};
      b_ext = {{HALF{dec_signed & in_b[HALF-1]}}, in_b[HALF-1:0]};
    end
    sign_a   = dec_signed & a_ext[XLEN-1];
    sign_b   = dec_signed & b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    // Word dividends are left-aligned so the iteration always consumes from the MSB
    dvd_init = dec_word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
    most_neg = dec_word ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    dz_in    = (b_ext == '0);
    ovf_in   = dec_signed & (a_ext == most_neg) & (b_ext == '1);
  end

  assign accept = in_valid & (state_reg == IDLE) & ~flush;

  div_restore_step #(.W(XLEN)) u_step (
    .rem_in   (rem_reg),
    .dvd_bit  (quo_reg[XLEN-1]),
    .divisor  (dvs_reg),
    .q_bit    (q_bit),
    .rem_next (rem_next)
  );

  always_comb begin
    q_raw    = {quo_reg[XLEN-2:0], q_bit};
    q_fix    = neg_q_reg ? -q_raw : q_raw;
    r_fix    = neg_r_reg ? -rem_next : rem_next;
    calc_res = finalize(dz_reg, ovf_reg, rem_sel_reg, word_reg, a_ext_reg, q_fix, r_fix);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
        state_next = (dz_in | ovf_in) ? DONE : CALC;
`else
        state_next = CALC;
`endif
      end
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      quo_reg        <= '0;
      rem_reg        <= '0;
      dvs_reg        <= '0;
      a_ext_reg      <= '0;
      out_result_reg <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      rem_sel_reg    <= 1'b0;
      word_reg       <= 1'b0;
      dz_reg         <= 1'b0;
      ovf_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg <= (state_next == DONE);
      if (accept) begin
        cnt_reg     <= dec_word ? CW'(HALF - 1) : CW'(XLEN - 1);
        quo_reg     <= dvd_init;
        rem_reg     <= '0;
        dvs_reg     <= mag_b;
        a_ext_reg   <= a_ext;
        neg_q_reg   <= sign_a ^ sign_b;
        neg_r_reg   <= sign_a;
        rem_sel_reg <= dec_rem;
        word_reg    <= dec_word;
        dz_reg      <= dz_in;
        ovf_reg     <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
        if (dz_in | ovf_in)
          out_result_reg <= finalize(dz_in, ovf_in, dec_rem, dec_word, a_ext, '0, '0);
`endif
      end else if (state_reg == CALC && !flush) begin
        quo_reg <= q_raw;
        rem_reg <= rem_next;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == '0) out_result_reg <= calc_res;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;

endmodule
